// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART-driven instruction memory loader.
package imem_uart_loader_pkg;

    localparam int unsigned IMEM_AW   = 13;
    localparam int unsigned IMEM_DW   = 32;
    localparam int unsigned LDR_LEN_W = 16;

    localparam logic [7:0] LDR_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_SYNC,
        LDR_LEN_LO,
        LDR_LEN_HI,
        LDR_DATA,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERR
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic               we;
        logic [IMEM_AW-1:0] addr;
        logic [IMEM_DW-1:0] data;
    } imem_wr_t;

    // Word index to word-aligned byte address.
    function automatic logic [IMEM_AW-1:0] word_to_byte_addr(input logic [IMEM_AW-3:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the line, times the bits and emits one byte
// (or a framing error) per character as single-cycle pulses.
module uart_rx_byte
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       frm_err_o
);

    localparam int unsigned         CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            // Mid-start recheck rejects short low glitches.
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        vld_d  = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_vld_o = vld_q;
    assign byte_o     = byte_q;
    assign frm_err_o  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed program image from UART into imem while holding the CPU core
// in reset; releases the core once the image checksum matches.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_WORDS    = 2048,
    parameter int unsigned TIMEOUT_CLKS = 4_340_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx,
    input  logic               load_req,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [IMEM_DW-1:0] imem_wdata,
    output logic               cpu_rst_n,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);

    logic       rx_vld;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (uart_rx),
        .byte_vld_o(rx_vld),
        .byte_o    (rx_byte),
        .frm_err_o (rx_ferr)
    );

    ldr_state_e           state_q, state_d;
    logic [LDR_LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           lane_q, lane_d;
    logic [23:0]          buf_q, buf_d;
    logic [7:0]           csum_q, csum_d;
    logic [TO_W-1:0]      gap_q, gap_d;
    imem_wr_t             wr_q, wr_d;
    logic                 cpu_rst_n_q, cpu_rst_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 active_c;
    logic                 timeout_c;
    logic [LDR_LEN_W-1:0] len_new_c;

    assign active_c  = (state_q == LDR_LEN_LO) || (state_q == LDR_LEN_HI) ||
                       (state_q == LDR_DATA)   || (state_q == LDR_CSUM);
    assign timeout_c = (gap_q == TO_W'(TIMEOUT_CLKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LDR_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            buf_q       <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
            wr_q        <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            csum_q      <= csum_d;
            gap_q       <= gap_d;
            wr_q        <= wr_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        csum_d    = csum_q;
        wr_d      = wr_q;
        wr_d.we   = 1'b0;
        len_new_c = {rx_byte, len_q[7:0]};

        // Inter-byte gap counter, saturating at the timeout value.
        if (rx_vld) begin
            gap_d = '0;
        end else if (timeout_c) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + TO_W'(1);
        end

        // Dropping load_req aborts from any state; abort beats every other event.
        if (!load_req) begin
            state_d = LDR_IDLE;
        end else if (active_c && (rx_ferr || timeout_c)) begin
            state_d = LDR_ERR;
        end else begin
            unique case (state_q)
                LDR_IDLE: state_d = LDR_SYNC;
                LDR_SYNC: begin
                    if (rx_vld && (rx_byte == LDR_SYNC_BYTE)) begin
                        state_d = LDR_LEN_LO;
                    end
                end
                LDR_LEN_LO: begin
                    if (rx_vld) begin
                        len_d[7:0] = rx_byte;
                        state_d    = LDR_LEN_HI;
                    end
                end
                LDR_LEN_HI: begin
                    if (rx_vld) begin
                        len_d = len_new_c;
                        if ((len_new_c == '0) || (len_new_c > LDR_LEN_W'(MAX_WORDS))) begin
                            state_d = LDR_ERR;
                        end else begin
                            idx_d   = '0;
                            lane_d  = '0;
                            csum_d  = '0;
                            state_d = LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    // Leave DATA only after the final word's write cycle.
                    if (wr_q.we && (LDR_LEN_W'(idx_q) == len_q)) begin
                        state_d = LDR_CSUM;
                    end else if (rx_vld) begin
                        csum_d = csum_q ^ rx_byte;
                        lane_d = lane_q + 2'd1;
                        unique case (lane_q)
                            2'd0: buf_d[7:0]   = rx_byte;
                            2'd1: buf_d[15:8]  = rx_byte;
                            2'd2: buf_d[23:16] = rx_byte;
                            default: begin
                                wr_d.we   = 1'b1;
                                wr_d.addr = word_to_byte_addr((IMEM_AW - 2)'(idx_q));
                                wr_d.data = {rx_byte, buf_q};
                                idx_d     = idx_q + IDX_W'(1);
                            end
                        endcase
                    end
                end
                LDR_CSUM: begin
                    if (rx_vld) begin
                        state_d = (rx_byte == csum_q) ? LDR_DONE : LDR_ERR;
                    end
                end
                LDR_DONE: state_d = LDR_DONE;
                LDR_ERR:  state_d = LDR_ERR;
                default:  state_d = LDR_IDLE;
            endcase
        end

        cpu_rst_n_d = (state_d == LDR_IDLE) || (state_d == LDR_DONE);
        busy_d      = (state_d == LDR_SYNC) || (state_d == LDR_LEN_LO) ||
                      (state_d == LDR_LEN_HI) || (state_d == LDR_DATA) ||
                      (state_d == LDR_CSUM);
        done_d      = (state_d == LDR_DONE);
        err_d       = (state_d == LDR_ERR);
    end

    assign imem_we    = wr_q.we;
    assign imem_waddr = wr_q.addr;
    assign imem_wdata = wr_q.data;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frames are serialized onto uart_rx and
// imem writes are collected by a monitor and compared against the sent image.
module tb_imem_uart_loader;

    localparam int unsigned CPB  = 10;
    localparam int unsigned MAXW = 8;
    localparam int unsigned TO   = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        load_req = 1'b0;
    logic        imem_we;
    logic [12:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .load_req  (load_req),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          we_outside = 0;
    logic [12:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] exp_w[$];
    logic [7:0]  txb[$];

    // Write monitor; a write while not busy means imem_we left the DATA phase.
    always @(negedge clk) begin
        if (imem_we) begin
            wa_q.push_back(imem_waddr);
            wd_q.push_back(imem_wdata);
            if (!busy) we_outside++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (txb.size() > 0) send_byte(txb.pop_front(), 1'b1);
        end
    endtask

    // Sync, length, exp_w as LE bytes, then XOR checksum (optionally corrupted).
    task automatic push_frame(input logic [15:0] len, input logic [7:0] csum_flip);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h00;
        txb.push_back(8'hA5);
        txb.push_back(len[7:0]);
        txb.push_back(len[15:8]);
        for (int i = 0; i < exp_w.size(); i++) begin
            w = exp_w[i];
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                txb.push_back(w[8*k +: 8]);
            end
        end
        txb.push_back(cs ^ csum_flip);
    endtask

    task automatic check_writes();
        check("wr_count", 32'(wa_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < wa_q.size() && i < exp_w.size(); i++) begin
            check("wr_addr", 32'(wa_q[i]), 32'(i * 4));
            check("wr_data", wd_q[i], exp_w[i]);
        end
    endtask

    task automatic start_load();
        wa_q.delete();
        wd_q.delete();
        txb.delete();
        exp_w.delete();
        load_req = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drop_load(input string tag);
        load_req = 1'b0;
        @(negedge clk);
        check({tag, "_rel_done"}, 32'(done), 32'd0);
        check({tag, "_rel_err"}, 32'(err), 32'd0);
        check({tag, "_rel_busy"}, 32'(busy), 32'd0);
        check({tag, "_rel_cpu"}, 32'(cpu_rst_n), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int waited;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_cpu", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cpu", 32'(cpu_rst_n), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Normal two-word load with junk before sync and a short glitch mid-word
        start_load();
        check("sync_busy", 32'(busy), 32'd1);
        check("sync_cpu", 32'(cpu_rst_n), 32'd0);
        exp_w.push_back(32'h0000_0013);
        exp_w.push_back(32'h0010_0093);
        txb.push_back(8'h00);
        txb.push_back(8'hFF);
        push_frame(16'd2, 8'h00);
        check("csum_byte", 32'(txb[txb.size() - 1]), 32'h90);
        send_n(6);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_n(100);
        check("ok_done", 32'(done), 32'd1);
        check("ok_err", 32'(err), 32'd0);
        check("ok_busy", 32'(busy), 32'd0);
        check("ok_cpu", 32'(cpu_rst_n), 32'd1);
        check_writes();
        drop_load("ok");

        // Bad checksum
        start_load();
        exp_w.push_back(32'h0000_0013);
        exp_w.push_back(32'h0010_0093);
        push_frame(16'd2, 8'h01);
        send_n(100);
        check("bad_err", 32'(err), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_cpu", 32'(cpu_rst_n), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        check_writes();
        drop_load("bad");

        // Zero length
        start_load();
        push_frame(16'd0, 8'h00);
        send_n(100);
        check("len0_err", 32'(err), 32'd1);
        check("len0_writes", 32'(wa_q.size()), 32'd0);
        drop_load("len0");

        // One word beyond capacity
        start_load();
        txb.push_back(8'hA5);
        txb.push_back(8'(MAXW + 1));
        txb.push_back(8'h00);
        send_n(100);
        check("lenmax1_err", 32'(err), 32'd1);
        check("lenmax1_writes", 32'(wa_q.size()), 32'd0);
        drop_load("lenmax1");

        // Full-capacity image
        start_load();
        for (int i = 0; i < MAXW; i++) begin
            exp_w.push_back({8'(i), 8'hC3, 8'(i * 7), 8'h5A});
        end
        push_frame(16'(MAXW), 8'h00);
        send_n(100);
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check_writes();
        if (wa_q.size() > 0) check("full_last_addr", 32'(wa_q[wa_q.size() - 1]), 32'((MAXW - 1) * 4));
        drop_load("full");

        // Stop bit low during DATA
        start_load();
        txb.push_back(8'hA5);
        txb.push_back(8'h01);
        txb.push_back(8'h00);
        send_n(3);
        send_byte(8'h11, 1'b0);
        check("stop0_err", 32'(err), 32'd1);
        check("stop0_busy", 32'(busy), 32'd0);
        check("stop0_writes", 32'(wa_q.size()), 32'd0);
        drop_load("stop0");

        // Timeout after two data bytes
        start_load();
        txb.push_back(8'hA5);
        txb.push_back(8'h01);
        txb.push_back(8'h00);
        txb.push_back(8'h11);
        txb.push_back(8'h22);
        send_n(5);
        repeat (TO / 2) @(negedge clk);
        check("to_early_err", 32'(err), 32'd0);
        waited = 0;
        while (!err && waited < 2 * TO) begin
            @(negedge clk);
            waited++;
        end
        check("to_err", 32'(err), 32'd1);
        check("to_writes", 32'(wa_q.size()), 32'd0);
        drop_load("to");

        // Abort mid-word: no partial write, even if the last lane byte follows
        start_load();
        txb.push_back(8'hA5);
        txb.push_back(8'h01);
        txb.push_back(8'h00);
        txb.push_back(8'h11);
        txb.push_back(8'h22);
        txb.push_back(8'h33);
        send_n(6);
        drop_load("abort");
        send_byte(8'h44, 1'b1);
        check("abort_writes", 32'(wa_q.size()), 32'd0);

        // Asynchronous reset mid-DATA
        start_load();
        txb.push_back(8'hA5);
        txb.push_back(8'h02);
        txb.push_back(8'h00);
        txb.push_back(8'h11);
        txb.push_back(8'h22);
        send_n(5);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", 32'(imem_we), 32'd0);
        check("arst_waddr", 32'(imem_waddr), 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_cpu", 32'(cpu_rst_n), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        load_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cpu", 32'(cpu_rst_n), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        repeat (3 * CPB) @(negedge clk);
        check("post_rst_writes", 32'(wa_q.size()), 32'd0);

        check("we_outside_data", 32'(we_outside), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
